// File: rtl/updown_btn_ctrl.sv
// Button front-end for the 4-bit up/down counter: synchronise, debounce, arbitrate, auto-repeat.
// Optional COUNT_LIMIT_EN masks inc at 4'hF and dec at 4'h0 without touching FSM sequencing.
module updown_btn_ctrl #(
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int TMR_W         = 26
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] count_in,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       busy
);

  localparam logic [TMR_W-1:0] DEB_LAST = TMR_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] RPT_LD   = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FIRE, HOLD, RPT, WAIT_REL} state_t;

  logic [1:0] raw;
  logic [1:0] deb;
  logic       deb_up;
  logic       deb_down;

  assign raw      = {btn_down, btn_up};
  assign deb_up   = deb[0];
  assign deb_down = deb[1];

  // Index 0 = up, 1 = down. The debounced level flips only after DEB_CYCLES
  // consecutive synchronised samples that disagree with it.
  for (genvar i = 0; i < 2; i++) begin : g_in
    logic [1:0]       sync;
    logic [TMR_W-1:0] cnt;
    logic             level;

    always_ff @(posedge clk) begin
      if (rst_p) begin
        sync  <= 2'b00;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        sync <= {sync[0], raw[i]};
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == DEB_LAST) begin
          cnt   <= '0;
          level <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign deb[i] = level;
  end

  logic block_inc;
  logic block_dec;

`ifdef COUNT_LIMIT_EN
  assign block_inc = (count_in == 4'hF);
  assign block_dec = (count_in == 4'h0);
`else
  logic unused_count;
  assign block_inc    = 1'b0;
  assign block_dec    = 1'b0;
  assign unused_count = ^count_in;
`endif

  state_t           state;
  logic             dir_up;
  logic [TMR_W-1:0] timer;
  logic             owner;

  assign owner = dir_up ? deb_up : deb_down;

  // The timer is loaded on the same edge that raises a pulse, so the first
  // repeat lands HOLD_CYCLES after the FIRE pulse and repeats REPEAT_CYCLES apart.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state     <= IDLE;
      dir_up    <= 1'b1;
      timer     <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_up || deb_down) begin
            dir_up    <= deb_up;
            inc_pulse <= deb_up && !block_inc;
            dec_pulse <= !deb_up && !block_dec;
            timer     <= HOLD_LD;
            state     <= FIRE;
            busy      <= 1'b1;
          end
        end
        FIRE, HOLD, RPT: begin
          if (!owner) begin
            state <= WAIT_REL;
          end else if (timer == '0) begin
            inc_pulse <= dir_up && !block_inc;
            dec_pulse <= !dir_up && !block_dec;
            timer     <= RPT_LD;
            state     <= RPT;
          end else begin
            timer <= timer - 1'b1;
            if (state == FIRE) state <= HOLD;
          end
        end
        WAIT_REL: begin
          if (!deb_up && !deb_down) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Directed bench for updown_btn_ctrl with short debounce/hold/repeat timings.
module tb_updown_btn_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;

`ifdef COUNT_LIMIT_EN
  localparam int LIMITED_PULSES = 0;
`else
  localparam int LIMITED_PULSES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_p;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] count_in;
  logic       inc_pulse;
  logic       dec_pulse;
  logic       busy;

  always #5 clk = ~clk;

  updown_btn_ctrl #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TMR_W(8)
  ) dut (
    .clk(clk), .rst_p(rst_p), .btn_up(btn_up), .btn_down(btn_down),
    .count_in(count_in), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse), .busy(busy)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_inc, n_dec, n_ovl;
  logic busy_seen;
  logic prev_inc = 1'b0;
  logic prev_dec = 1'b0;

  typedef struct {
    logic       up;
    logic       dn;
    logic [3:0] cnt;
    int         cycles;
    int         e_inc;
    int         e_dec;
    logic       e_seen;
    logic       e_end;
  } vec_t;

  vec_t vt[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_inc     = 0;
    n_dec     = 0;
    n_ovl     = 0;
    busy_seen = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (inc_pulse === 1'b1) n_inc++;
    if (dec_pulse === 1'b1) n_dec++;
    if (inc_pulse === 1'b1 && dec_pulse === 1'b1) n_ovl++;
    if ((inc_pulse === 1'b1 && prev_inc) || (dec_pulse === 1'b1 && prev_dec)) n_ovl++;
    prev_inc = (inc_pulse === 1'b1);
    prev_dec = (dec_pulse === 1'b1);
    if (busy === 1'b1) busy_seen = 1'b1;
  endtask

  initial begin
    int t0;
    int k;
    int offs[$];
    int exp_offs[6];

    exp_offs = '{0, HOLD, HOLD + REP, HOLD + 2*REP, HOLD + 3*REP, HOLD + 4*REP};

    // up, dn, count_in, cycles, inc, dec, busy seen, busy at end
    vt[0]  = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 4'h0, 15, 1, 0, 1'b1, 1'b1};
    vt[2]  = '{1'b0, 1'b0, 4'h0, DEB + 4, 0, 0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'h0, 2, 0, 0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 4'h0, 12, 0, 0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 4'h5, 15, 1, 0, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 4'h5, 20, 0, 0, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 4'h5, 10, 0, 0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 4'h5, 15, 0, 1, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 4'h5, 10, 0, 0, 1'b1, 1'b0};
    vt[10] = '{1'b1, 1'b0, 4'hF, 15, LIMITED_PULSES, 0, 1'b1, 1'b1};
    vt[11] = '{1'b0, 1'b0, 4'hF, 10, 0, 0, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 4'h0, 15, 0, LIMITED_PULSES, 1'b1, 1'b1};
    vt[13] = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 4'hF, 15, 0, 1, 1'b1, 1'b1};
    vt[15] = '{1'b0, 1'b0, 4'hF, 10, 0, 0, 1'b1, 1'b0};

    rst_p    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    count_in = 4'h0;
    clear_stats();
    repeat (3) step();
    check("rst_inc", inc_pulse, 1'b0);
    check("rst_dec", dec_pulse, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_p = 1'b0;

    for (int i = 0; i < 16; i++) begin
      btn_up   = vt[i].up;
      btn_down = vt[i].dn;
      count_in = vt[i].cnt;
      clear_stats();
      repeat (vt[i].cycles) step();
      check($sformatf("v%0d_inc", i), n_inc, vt[i].e_inc);
      check($sformatf("v%0d_dec", i), n_dec, vt[i].e_dec);
      check($sformatf("v%0d_overlap", i), n_ovl, 0);
      check($sformatf("v%0d_busy_seen", i), busy_seen, vt[i].e_seen);
      check($sformatf("v%0d_busy_end", i), busy, vt[i].e_end);
    end

    // Hold-to-repeat: first pulse, then HOLD later, then every REP.
    count_in = 4'h3;
    clear_stats();
    btn_up = 1'b1;
    k = 0;
    while (inc_pulse !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check("hold_first_seen", inc_pulse, 1'b1);
    check("hold_first_lat", k, DEB + 3);
    t0 = cyc;
    offs.push_back(0);
    repeat (HOLD + 4*REP + 1) begin
      step();
      if (inc_pulse === 1'b1) offs.push_back(cyc - t0);
    end
    btn_up = 1'b0;
    repeat (20) begin
      step();
      if (inc_pulse === 1'b1) offs.push_back(cyc - t0);
    end
    check("hold_pulse_count", offs.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < offs.size()) check($sformatf("hold_off%0d", i), offs[i], exp_offs[i]);
    end
    check("hold_dec", n_dec, 0);
    check("hold_overlap", n_ovl, 0);
    check("hold_busy_end", busy, 1'b0);

    // Reset on the edge where a repeat pulse is due, then re-debounce a held button.
    clear_stats();
    btn_up = 1'b1;
    k = 0;
    while (inc_pulse !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check("rst_seq_first", inc_pulse, 1'b1);
    repeat (HOLD + REP - 1) step();
    check("rst_seq_in_rpt", n_inc, 2);
    rst_p = 1'b1;
    step();
    check("rst_mid_inc", inc_pulse, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    rst_p = 1'b0;
    clear_stats();
    k = 0;
    while (inc_pulse !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    check("rst_redeb_seen", inc_pulse, 1'b1);
    check("rst_redeb_lat", k, DEB + 3);
    repeat (8) step();
    check("rst_redeb_count", n_inc, 1);
    btn_up = 1'b0;
    repeat (DEB + 6) step();
    check("rst_final_busy", busy, 1'b0);
    check("rst_final_dec", n_dec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
